// File: rtl/key_event_bank.sv
// key_event_bank: per-key sync, debounce, press/release/long events; auto-repeat via KEY_EVENT_AUTO_REPEAT_EN
module key_event_bank #(
  parameter int N_KEYS        = 3,
  parameter int DEB_CYCLES    = 4,
  parameter int LONG_CYCLES   = 16,
  parameter int REPEAT_CYCLES = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long
);
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic s1, s2, lvl, press, rel, lng;
    logic [7:0] deb_cnt;
    logic [15:0] hold_cnt;
    state_t state;
    logic accept, rise, fall, long_hit, rep_hit;
    assign accept   = (s2 != lvl) && (deb_cnt == 8'(DEB_CYCLES - 1));
    assign rise     = accept && s2;
    assign fall     = accept && !s2;
    assign long_hit = (state == HELD) && (hold_cnt == 16'(LONG_CYCLES - 1));
`ifdef KEY_EVENT_AUTO_REPEAT_EN
    logic [15:0] rep_cnt;
    assign rep_hit = (state == LONG) && (rep_cnt == 16'(REPEAT_CYCLES - 1)) && !fall;
    always_ff @(posedge clk)
      rep_cnt <= (nrst || state != LONG || rep_hit) ? '0 : rep_cnt + 16'd1;
`else
    logic unused_repeat;
    assign unused_repeat = REPEAT_CYCLES[0];
    assign rep_hit = 1'b0;
`endif
    always_ff @(posedge clk) begin
      if (nrst) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        lvl      <= 1'b0;
        press    <= 1'b0;
        rel      <= 1'b0;
        lng      <= 1'b0;
        deb_cnt  <= '0;
        hold_cnt <= '0;
        state    <= IDLE;
      end else begin
        s1      <= i_key[g];
        s2      <= s1;
        deb_cnt <= (s2 == lvl || accept) ? '0 : deb_cnt + 8'd1;
        lvl     <= accept ? s2 : lvl;
        press   <= rise || rep_hit;
        rel     <= fall;
        lng     <= long_hit && !fall;
        if (fall) state <= IDLE;
        else if (rise) begin
          state    <= HELD;
          hold_cnt <= '0;
        end else if (long_hit) state <= LONG;
        else if (state == HELD && hold_cnt != '1) hold_cnt <= hold_cnt + 16'd1;
      end
    end
    assign o_level[g]   = lvl;
    assign o_press[g]   = press;
    assign o_release[g] = rel;
    assign o_long[g]    = lng;
  end
endmodule

// File: tb/tb_key_event_bank.sv
// tb_key_event_bank: scoreboard bench with a sample-history reference model
module tb_key_event_bank;
  localparam int N = 3, DEB = 4, LONG = 16, REP = 8;
  logic clk = 1'b0;
  logic nrst;
  logic [N-1:0] i_key, o_level, o_press, o_release, o_long;
  always #5 clk = ~clk;

  key_event_bank #(.N_KEYS(N), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .nrst(nrst), .i_key(i_key), .o_level(o_level),
    .o_press(o_press), .o_release(o_release), .o_long(o_long)
  );

  typedef struct packed {logic [N-1:0] lvl, prs, rel, lng;} exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0, t = 0, mon_t = 0;
  logic [N-1:0] m_lvl, k1, k2;
  logic [DEB-1:0] hist [N];
  int press_t [N];

  // Level flips once the last DEB synchronised samples all disagree with it;
  // events are derived from the age of the current press.
  task automatic step(input logic r, input logic [N-1:0] k);
    exp_t e;
    e = '0;
    nrst = r;
    i_key = k;
    t++;
    if (r) begin
      m_lvl = '0;
      k1 = '0;
      k2 = '0;
      for (int i = 0; i < N; i++) begin
        hist[i] = '0;
        press_t[i] = -100000;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        int age;
        hist[i] = {hist[i][DEB-2:0], k2[i]};
        if (m_lvl[i] ? (hist[i] == '0) : (&hist[i])) begin
          m_lvl[i] = ~m_lvl[i];
          e.prs[i] = m_lvl[i];
          e.rel[i] = ~m_lvl[i];
          if (m_lvl[i]) press_t[i] = t;
        end
        age = t - press_t[i];
        if (m_lvl[i] && age == LONG) e.lng[i] = 1'b1;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
        if (m_lvl[i] && age > LONG && (age - LONG) % REP == 0) e.prs[i] = 1'b1;
`endif
      end
      k2 = k1;
      k1 = k;
    end
    e.lvl = m_lvl;
    q.push_back(e);
    @(negedge clk);
  endtask

  function automatic void chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, mon_t, act, exp);
    end
  endfunction

  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    mon_t++;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("o_level", o_level, e.lvl);
      chk("o_press", o_press, e.prs);
      chk("o_release", o_release, e.rel);
      chk("o_long", o_long, e.lng);
    end
  end

  initial begin
    int run [N];
    logic [N-1:0] key;
    step(1'b1, '1);
    step(1'b1, '1);
    repeat (12) step(1'b0, 3'b111);
    repeat (10) step(1'b0, 3'b000);
    repeat (3) step(1'b0, 3'b001);
    repeat (10) step(1'b0, 3'b000);
    repeat (10) step(1'b0, 3'b010);
    repeat (12) step(1'b0, 3'b000);
    repeat (40) step(1'b0, 3'b100);
    repeat (12) step(1'b0, 3'b000);
    repeat (8) step(1'b0, 3'b101);
    repeat (10) step(1'b0, 3'b000);
    repeat (16) step(1'b0, 3'b100);
    repeat (10) step(1'b0, 3'b000);
    repeat (15) step(1'b0, 3'b010);
    repeat (10) step(1'b0, 3'b000);
    repeat (17) step(1'b0, 3'b001);
    repeat (10) step(1'b0, 3'b000);
    repeat (10) step(1'b0, 3'b010);
    step(1'b1, 3'b010);
    repeat (15) step(1'b0, 3'b010);
    repeat (12) step(1'b0, 3'b000);
    key = '0;
    for (int i = 0; i < N; i++) run[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (run[i] == 0) begin
          key[i] = ~key[i];
          run[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(4, 40));
        end else run[i]--;
      end
      step($urandom_range(0, 399) == 0, key);
    end
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
